// File: rtl/ball_engine_if.sv
// Signal bundle between the pong ball engine and the frame/paddle/score logic around it.
interface ball_engine_if;
    logic       frame_tick;
    logic       serve;
    logic [9:0] paddle_1Y;
    logic [9:0] paddle_2Y;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       point;
    logic       game_over;

    modport master (
        output frame_tick, serve, paddle_1Y, paddle_2Y,
        input  ballX, ballY, score_1, score_2, point, game_over
    );

    modport slave (
        input  frame_tick, serve, paddle_1Y, paddle_2Y,
        output ballX, ballY, score_1, score_2, point, game_over
    );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: ball motion, wall/paddle bounces, scoring and the serve/hold/game-over flow.
// Optional macro BALL_SPEEDUP_EN: every paddle hit speeds the ball up horizontally (dx 2..6).
module ball_engine #(
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 60,
    parameter int X_P1        = 20,
    parameter int X_P2        = 612,
    parameter int Y_TOP       = 30,
    parameter int Y_BOT       = 450,
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 60
) (
    input  logic         clk,
    input  logic         rst,
    ball_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, SCORED, GAME_OVER} state_t;

    localparam logic [9:0]  X_CTR     = 10'd316;
    localparam logic [9:0]  Y_CTR     = 10'd236;
    localparam logic [3:0]  STEP_INIT = 4'd2;
    localparam logic [9:0]  DY        = 10'd2;
    localparam logic [10:0] XP1       = 11'(X_P1);
    localparam logic [10:0] XP2       = 11'(X_P2);
    localparam logic [10:0] YTOP      = 11'(Y_TOP);
    localparam logic [10:0] YBOT      = 11'(Y_BOT);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] PH        = 11'(PADDLE_H);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
    localparam int          HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    state_t        state, state_nxt;
    logic [9:0]    ball_x, ball_x_nxt, ball_y, ball_y_nxt;
    logic [3:0]    dx, dx_nxt, dx_hit;
    logic          xdir, xdir_nxt, ydir, ydir_nxt;
    logic          serve_xdir, serve_xdir_nxt, serve_ydir, serve_ydir_nxt;
    logic [3:0]    score_1, score_1_nxt, score_2, score_2_nxt;
    logic          point, point_nxt, miss;
    logic [HW-1:0] hold_cnt, hold_nxt;

    // Boundary maths in 11 bits so sums never wrap and nothing is ever subtracted.
    logic [10:0] bx, by, dxw, dyw, p1, p2;
    logic        cover_1, cover_2;
    assign bx      = {1'b0, ball_x};
    assign by      = {1'b0, ball_y};
    assign dxw     = {7'b0, dx};
    assign dyw     = {1'b0, DY};
    assign p1      = {1'b0, bus.paddle_1Y};
    assign p2      = {1'b0, bus.paddle_2Y};
    assign cover_1 = (by + BSZ > p1) && (by < p1 + PH);
    assign cover_2 = (by + BSZ > p2) && (by < p2 + PH);

`ifdef BALL_SPEEDUP_EN
    localparam logic [3:0] DX_MAX = 4'd6;
    assign dx_hit = (dx < DX_MAX) ? dx + 4'd1 : dx;
`else
    assign dx_hit = STEP_INIT;
`endif

    always_comb begin
        // NOTE: every target takes its held value first, so no branch can infer a latch.
        state_nxt      = state;
        ball_x_nxt     = ball_x;
        ball_y_nxt     = ball_y;
        dx_nxt         = dx;
        xdir_nxt       = xdir;
        ydir_nxt       = ydir;
        serve_xdir_nxt = serve_xdir;
        serve_ydir_nxt = serve_ydir;
        score_1_nxt    = score_1;
        score_2_nxt    = score_2;
        hold_nxt       = hold_cnt;
        point_nxt      = 1'b0;
        miss           = 1'b0;
        unique case (state)
            IDLE: begin
                ball_x_nxt = X_CTR;
                ball_y_nxt = Y_CTR;
                if (bus.serve) begin
                    state_nxt      = PLAY;
                    xdir_nxt       = serve_xdir;
                    ydir_nxt       = serve_ydir;
                    serve_ydir_nxt = ~serve_ydir;
                    dx_nxt         = STEP_INIT;
                end
            end
            PLAY: if (bus.frame_tick) begin
                if (!ydir && by <= YTOP + dyw) begin
                    ball_y_nxt = YTOP[9:0];
                    ydir_nxt   = 1'b1;
                end else if (!ydir) begin
                    ball_y_nxt = ball_y - DY;
                end else if (by + dyw >= YBOT) begin
                    ball_y_nxt = YBOT[9:0];
                    ydir_nxt   = 1'b0;
                end else begin
                    ball_y_nxt = ball_y + DY;
                end
                ball_x_nxt = xdir ? ball_x + {6'b0, dx} : ball_x - {6'b0, dx};
                if (!xdir && bx <= XP1 + dxw) begin
                    if (cover_1) begin
                        ball_x_nxt = XP1[9:0];
                        xdir_nxt   = 1'b1;
                        dx_nxt     = dx_hit;
                    end else begin
                        miss           = 1'b1;
                        score_2_nxt    = (score_2 == WIN) ? WIN : score_2 + 4'd1;
                        serve_xdir_nxt = 1'b0;
                    end
                end else if (xdir && bx + dxw >= XP2) begin
                    if (cover_2) begin
                        ball_x_nxt = XP2[9:0];
                        xdir_nxt   = 1'b0;
                        dx_nxt     = dx_hit;
                    end else begin
                        miss           = 1'b1;
                        score_1_nxt    = (score_1 == WIN) ? WIN : score_1 + 4'd1;
                        serve_xdir_nxt = 1'b1;
                    end
                end
                // A miss freezes the ball where it was, overriding any wall bounce.
                if (miss) begin
                    ball_x_nxt = ball_x;
                    ball_y_nxt = ball_y;
                    ydir_nxt   = ydir;
                    point_nxt  = 1'b1;
                    hold_nxt   = '0;
                    state_nxt  = SCORED;
                end
            end
            SCORED: if (bus.frame_tick) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (score_1 == WIN || score_2 == WIN) begin
                        state_nxt = GAME_OVER;
                    end else begin
                        state_nxt  = IDLE;
                        ball_x_nxt = X_CTR;
                        ball_y_nxt = Y_CTR;
                    end
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            GAME_OVER: if (bus.serve) begin
                score_1_nxt = '0;
                score_2_nxt = '0;
                ball_x_nxt  = X_CTR;
                ball_y_nxt  = Y_CTR;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples values from before the edge.
        if (rst) begin
            state      <= IDLE;
            ball_x     <= X_CTR;
            ball_y     <= Y_CTR;
            dx         <= STEP_INIT;
            xdir       <= 1'b1;
            ydir       <= 1'b1;
            serve_xdir <= 1'b1;
            serve_ydir <= 1'b1;
            score_1    <= '0;
            score_2    <= '0;
            point      <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            ball_x     <= ball_x_nxt;
            ball_y     <= ball_y_nxt;
            dx         <= dx_nxt;
            xdir       <= xdir_nxt;
            ydir       <= ydir_nxt;
            serve_xdir <= serve_xdir_nxt;
            serve_ydir <= serve_ydir_nxt;
            score_1    <= score_1_nxt;
            score_2    <= score_2_nxt;
            point      <= point_nxt;
            hold_cnt   <= hold_nxt;
        end
    end

    assign bus.ballX     = ball_x;
    assign bus.ballY     = ball_y;
    assign bus.score_1   = score_1;
    assign bus.score_2   = score_2;
    assign bus.point     = point;
    assign bus.game_over = (state == GAME_OVER);
endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 8, ball square side in pixels.
REQ-002 SHALL have parameter PADDLE_H, default 60, paddle height in pixels.
REQ-003 SHALL have parameter X_P1, default 20, right face of paddle 1.
REQ-004 SHALL have parameter X_P2, default 612, left face of paddle 2 minus BALL_SIZE.
REQ-005 SHALL have parameter Y_TOP, default 30, and Y_BOT, default 450, the legal ballY range.
REQ-006 SHALL have parameter WIN_SCORE, default 9, points needed to win.
REQ-007 SHALL have parameter HOLD_FRAMES, default 60, post-point pause in frames.
REQ-008 SHALL have port clk, input, 1, the single system clock.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port frame_tick, input, 1, one-clk pulse per video frame.
REQ-011 SHALL have port serve, input, 1, one-clk pulse starting a rally or new game.
REQ-012 SHALL have ports paddle_1Y and paddle_2Y, input, 10 each, top Y of each paddle.
REQ-013 SHALL have ports ballX and ballY, output, 10 each, top-left of ball; ballY feeds AIMode.
REQ-014 SHALL have ports score_1 and score_2, output, 4 each, player scores.
REQ-015 SHALL have port point, output, 1, one-clk pulse when a point is awarded.
REQ-016 SHALL have port game_over, output, 1, high while in GAME_OVER.

Function
REQ-017 SHALL implement states IDLE, PLAY, SCORED and GAME_OVER.
REQ-018 IDLE: ball held at (316,236); serve moves to PLAY on the next clk.
REQ-019 PLAY: position SHALL update only on a frame_tick clk, from registered values, with 1-clk latency.
REQ-020 Step magnitudes are dx and dy (initially 2), with direction flags xdir (1=right) and ydir (1=down).
REQ-021 Boundary compares SHALL be done without unsigned underflow (e.g. ballY <= Y_TOP+dy, not ballY-dy).
REQ-022 Top wall: if moving up and ballY <= Y_TOP+dy, then ballY=Y_TOP and ydir=down.
REQ-023 Bottom wall: if moving down and ballY+dy >= Y_BOT, then ballY=Y_BOT and ydir=up.
REQ-024 Paddle overlap SHALL be ballY+BALL_SIZE > paddleY and ballY < paddleY+PADDLE_H.
REQ-025 Left crossing: if moving left and ballX <= X_P1+dx, then with paddle_1Y overlap ballX=X_P1 and xdir=right.
REQ-026 Left crossing without overlap: score_2 increments, point pulses, state goes to SCORED.
REQ-027 Right crossing: mirror of REQ-025/026 at X_P2 with paddle_2Y; a miss increments score_1.
REQ-028 Wall and paddle events in the same tick SHALL both apply; a miss takes priority over wall bounce.
REQ-029 SCORED: ball frozen; count HOLD_FRAMES frame_ticks.
REQ-030 At end of hold: go to GAME_OVER if either score equals WIN_SCORE, else go to IDLE.
REQ-031 Each serve SHALL send the ball toward the player who lost the last point (rightward for the first serve).
REQ-032 ydir SHALL alternate on every serve, starting down.
REQ-033 GAME_OVER: serve SHALL clear scores, recentre the ball and go to IDLE.
REQ-034 serve SHALL be ignored in PLAY and SCORED.
REQ-035 Scores SHALL saturate at WIN_SCORE.

Reset
REQ-036 rst SHALL set state=IDLE, ballX=316, ballY=236, scores=0, point=0, dx=dy=2, xdir=right, ydir=down, hold counter=0.
REQ-037 rst SHALL take priority over every other input, including mid-rally and mid-hold.

Configuration
REQ-038 Macro BALL_SPEEDUP_EN defined: each paddle hit SHALL increment dx by 1, to a maximum of 6; dx SHALL return to 2 on every serve.
REQ-039 Macro BALL_SPEEDUP_EN undefined: dx SHALL stay constant at 2.

Verification
REQ-040 Serve after reset, no paddle hit -> ballX +2 per frame_tick from 316; at right crossing, score_1=1, point pulses once, SCORED held for 60 ticks.
REQ-041 ballY=32 moving up, tick -> ballY=30, ydir=down; next tick ballY=32.
REQ-042 paddle_1Y=200, ball moving left with ballY=230 at ballX=22 -> ballX=20, xdir=right, no point.
REQ-043 paddle_1Y=200, ballY=100 at ballX=22 moving left -> score_2 increments, next serve goes left.
REQ-044 score_1 reaches 9 -> after hold, game_over=1; serve -> scores 0, game_over=0, state IDLE.
REQ-045 rst asserted mid-PLAY and mid-SCORED -> all outputs at reset values on the next clk; with BALL_SPEEDUP_EN, 5 hits -> dx=6, and a serve restores dx=2.
